control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multicycle control FSM that drives every control input of the RV64I datapath: RF/memory write enables, RF write-back mux, ALU operand mux, IR/PC load strobes and PC path selects.
- Consumes the opcode field of the instruction register (IR) and sequences the FETCH, DECODE, EXEC and MEM cycles.
- Flags illegal opcodes and counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  IR[6:0]; valid from DECODE onward.
- WE_RF  output  1  register file write enable.
- WE_MEM  output  1  data memory write enable.
- RF_din_sel  output  2  RF write source: 00 DM_out, 01 ALU result, 10 PC+4 (primary adder), 11 secondary adder (PC+imm / rs1+imm).
- ULA_din2_sel  output  1  ALU operand 2: 0 rs2, 1 immediate.
- load_pc  output  1  PC register load strobe.
- load_ir  output  1  IR load strobe.
- pc_next_sel  output  1  next-PC source: 0 PC+4, 1 secondary adder. For branches the PC block qualifies this with the ALU flags.
- pc_adder_sel  output  1  secondary adder base: 0 PC, 1 rs1.
- state  output  3  current state, for debug.
- illegal  output  1  high while in HALT.
- retired  output  COUNT_WIDTH  retired-instruction count.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4. The state register is the only FSM storage.
- Reset:
  - Reset sampled high forces state to FETCH and retired to 0 on the next edge.
  - All control outputs are combinational from state and opcode.
  - While reset is high, every control output is forced to 0.
  - Reset mid-instruction abandons that instruction; no partial write is committed after the reset edge.
- Default value of every control output is 0 unless listed below.
- FETCH:
  - load_ir=1.
  - Next state DECODE.
- DECODE:
  - No strobes; operands settle.
  - Next state EXEC if opcode is supported, else HALT.
- Supported opcodes: R 0110011, OP-32 0111011, I-ALU 0010011, OP-IMM-32 0011011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- EXEC, by opcode class:
  - R / OP-32: WE_RF=1, RF_din_sel=01, ULA_din2_sel=0, load_pc=1.
  - I-ALU / OP-IMM-32 / LUI: WE_RF=1, RF_din_sel=01, ULA_din2_sel=1, load_pc=1. The ALU resolves LUI from the opcode.
  - AUIPC: WE_RF=1, RF_din_sel=11, pc_adder_sel=0, load_pc=1.
  - STORE: ULA_din2_sel=1, WE_MEM=1, load_pc=1.
  - BRANCH: ULA_din2_sel=0, pc_next_sel=1, pc_adder_sel=0, load_pc=1.
  - JAL: WE_RF=1, RF_din_sel=10, pc_next_sel=1, pc_adder_sel=0, load_pc=1.
  - JALR: WE_RF=1, RF_din_sel=10, pc_next_sel=1, pc_adder_sel=1, load_pc=1.
  - LOAD: ULA_din2_sel=1 (address only), no strobes; next state MEM.
- Next state after EXEC: FETCH for every non-LOAD class.
- MEM (LOAD only):
  - ULA_din2_sel=1, WE_RF=1, RF_din_sel=00, load_pc=1.
  - Next state FETCH.
- RF write and PC update share one edge. PC+4 is sampled from the pre-update PC, so JAL/JALR link correctly.
- Latency: LOAD takes 4 cycles; every other class takes 3 cycles.
- HALT:
  - illegal=1, all control outputs 0.
  - Stays in HALT until reset.
- retired:
  - Increments by 1 on each edge where load_pc=1.
  - Wraps modulo 2^COUNT_WIDTH without saturating.
  - Does not increment in HALT or while reset is high.

Test Plan:
- Reset held 2 cycles, then R-type opcode 0110011 → state sequence 0,1,2,0; exactly one cycle with load_ir=1, then one with WE_RF=1, RF_din_sel=01, load_pc=1; retired=1.
- LOAD 0000011 → states 0,1,2,3,0; WE_RF is 0 in EXEC; in MEM, WE_RF=1, RF_din_sel=00, load_pc=1; retired increments only after MEM.
- STORE, then JAL, then JALR → STORE EXEC: WE_MEM=1, WE_RF=0. JAL EXEC: RF_din_sel=10, pc_next_sel=1, pc_adder_sel=0. JALR EXEC: pc_adder_sel=1. retired=3.
- BRANCH 1100011 → EXEC: WE_RF=0, WE_MEM=0, pc_next_sel=1, load_pc=1. AUIPC 0010111 → EXEC: RF_din_sel=11, pc_adder_sel=0.
- Illegal opcode 1111111 → DECODE→HALT; illegal=1 held for 10 cycles with all strobes 0 and retired frozen; reset → FETCH, illegal=0.
- Reset asserted during LOAD's MEM cycle → no WE_RF or load_pc commit at that edge; state=FETCH and retired=0 after reset. Preload retired to 2^COUNT_WIDTH-1 (COUNT_WIDTH=4, 15 retirements) → next retirement reads 0.

Source files
------------

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - opcode/control bundle between the control unit and the RV64I datapath
interface control_unit_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [6:0]             opcode;
  logic                   WE_RF;
  logic                   WE_MEM;
  logic [1:0]             RF_din_sel;
  logic                   ULA_din2_sel;
  logic                   load_pc;
  logic                   load_ir;
  logic                   pc_next_sel;
  logic                   pc_adder_sel;
  logic [2:0]             state;
  logic                   illegal;
  logic [COUNT_WIDTH-1:0] retired;

  modport master (
    input  opcode,
    output WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, load_ir,
           pc_next_sel, pc_adder_sel, state, illegal, retired
  );

  modport slave (
    output opcode,
    input  WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, load_ir,
           pc_next_sel, pc_adder_sel, state, illegal, retired
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RV64I control FSM with illegal-opcode halt and retire counter
module control_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic          CLK,
  input  logic          reset,
  control_unit_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t                 r_state;
  state_t                 w_next;
  logic [COUNT_WIDTH-1:0] r_retired;
  logic                   w_supported;
  logic                   w_we_rf;
  logic                   w_we_mem;
  logic [1:0]             w_rf_sel;
  logic                   w_ula_sel;
  logic                   w_load_pc;
  logic                   w_load_ir;
  logic                   w_pc_next_sel;
  logic                   w_pc_adder_sel;
  logic                   w_illegal;

  always_comb begin
    case (bus.opcode)
      OP_R, OP_32, OP_IALU, OP_IMM32, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_supported = 1'b1;
      default:                                       w_supported = 1'b0;
    endcase
  end

  always_comb begin
    w_next         = r_state;
    w_we_rf        = 1'b0;
    w_we_mem       = 1'b0;
    w_rf_sel       = 2'b00;
    w_ula_sel      = 1'b0;
    w_load_pc      = 1'b0;
    w_load_ir      = 1'b0;
    w_pc_next_sel  = 1'b0;
    w_pc_adder_sel = 1'b0;
    w_illegal      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_load_ir = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: w_next = w_supported ? S_EXEC : S_HALT;
      S_EXEC: begin
        w_next = S_FETCH;
        case (bus.opcode)
          OP_R, OP_32: begin
            w_we_rf = 1'b1; w_rf_sel = 2'b01; w_load_pc = 1'b1;
          end
          OP_IALU, OP_IMM32, OP_LUI: begin
            w_we_rf = 1'b1; w_rf_sel = 2'b01; w_ula_sel = 1'b1; w_load_pc = 1'b1;
          end
          OP_AUIPC: begin
            w_we_rf = 1'b1; w_rf_sel = 2'b11; w_load_pc = 1'b1;
          end
          OP_STORE: begin
            w_ula_sel = 1'b1; w_we_mem = 1'b1; w_load_pc = 1'b1;
          end
          OP_BRANCH: begin
            w_pc_next_sel = 1'b1; w_load_pc = 1'b1;
          end
          OP_JAL: begin
            w_we_rf = 1'b1; w_rf_sel = 2'b10; w_pc_next_sel = 1'b1; w_load_pc = 1'b1;
          end
          OP_JALR: begin
            w_we_rf = 1'b1; w_rf_sel = 2'b10; w_pc_next_sel = 1'b1;
            w_pc_adder_sel = 1'b1; w_load_pc = 1'b1;
          end
          // Address computed here; the write-back waits for the memory cycle.
          OP_LOAD: begin
            w_ula_sel = 1'b1;
            w_next    = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_ula_sel = 1'b1; w_we_rf = 1'b1; w_rf_sel = 2'b00; w_load_pc = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT:  w_illegal = 1'b1;
      default: w_next = S_FETCH;
    endcase
    // Reset abandons any in-flight instruction, so nothing may commit on that edge.
    if (reset) begin
      w_we_rf        = 1'b0;
      w_we_mem       = 1'b0;
      w_rf_sel       = 2'b00;
      w_ula_sel      = 1'b0;
      w_load_pc      = 1'b0;
      w_load_ir      = 1'b0;
      w_pc_next_sel  = 1'b0;
      w_pc_adder_sel = 1'b0;
      w_illegal      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_pc) r_retired <= r_retired + COUNT_WIDTH'(1);
    end
  end

  assign bus.WE_RF        = w_we_rf;
  assign bus.WE_MEM       = w_we_mem;
  assign bus.RF_din_sel   = w_rf_sel;
  assign bus.ULA_din2_sel = w_ula_sel;
  assign bus.load_pc      = w_load_pc;
  assign bus.load_ir      = w_load_ir;
  assign bus.pc_next_sel  = w_pc_next_sel;
  assign bus.pc_adder_sel = w_pc_adder_sel;
  assign bus.state        = r_state;
  assign bus.illegal      = w_illegal;
  assign bus.retired      = r_retired;
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a per-instruction cycle-plan model
module tb_control_unit;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  control_unit_if #(.COUNT_WIDTH(CW)) bus();
  control_unit #(.COUNT_WIDTH(CW)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  int model_ret = 0;

  // ctrl bits: {WE_RF, WE_MEM, RF_din_sel[1:0], ULA_din2_sel, load_ir, load_pc, pc_next_sel, pc_adder_sel}
  typedef struct packed {
    logic [2:0] st;
    logic [8:0] ctrl;
    logic       ill;
  } exp_t;

  localparam logic [6:0] R = 7'b0110011, O32 = 7'b0111011, IA = 7'b0010011, I32 = 7'b0011011;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic [6:0] ops [0:10] = '{R, O32, IA, I32, LD, ST, BR, JAL, JALR, LUI, AUIPC};

  function automatic logic [8:0] mk(input logic we_rf, input logic we_mem, input logic [1:0] rf_sel,
                                    input logic ula, input logic lir, input logic lpc,
                                    input logic pns, input logic pas);
    return {we_rf, we_mem, rf_sel, ula, lir, lpc, pns, pas};
  endfunction

  function automatic bit supported(input logic [6:0] op);
    for (int i = 0; i < 11; i++) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] exec_ctrl(input logic [6:0] op);
    case (op)
      R, O32:       return mk(1, 0, 2'b01, 0, 0, 1, 0, 0);
      IA, I32, LUI: return mk(1, 0, 2'b01, 1, 0, 1, 0, 0);
      AUIPC:        return mk(1, 0, 2'b11, 0, 0, 1, 0, 0);
      ST:           return mk(0, 1, 2'b00, 1, 0, 1, 0, 0);
      BR:           return mk(0, 0, 2'b00, 0, 0, 1, 1, 0);
      JAL:          return mk(1, 0, 2'b10, 0, 0, 1, 1, 0);
      JALR:         return mk(1, 0, 2'b10, 0, 0, 1, 1, 1);
      LD:           return mk(0, 0, 2'b00, 1, 0, 0, 0, 0);
      default:      return 9'h000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] obs_ctrl();
    return {bus.WE_RF, bus.WE_MEM, bus.RF_din_sel, bus.ULA_din2_sel, bus.load_ir,
            bus.load_pc, bus.pc_next_sel, bus.pc_adder_sel};
  endfunction

  // Checks one cycle per plan entry, starting at a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] op, input int halt_cycles, input int limit);
    exp_t plan[$];
    plan.push_back('{st: 3'd0, ctrl: mk(0, 0, 2'b00, 0, 1, 0, 0, 0), ill: 1'b0});
    plan.push_back('{st: 3'd1, ctrl: 9'h000, ill: 1'b0});
    if (!supported(op)) begin
      for (int i = 0; i < halt_cycles; i++) plan.push_back('{st: 3'd4, ctrl: 9'h000, ill: 1'b1});
    end else begin
      plan.push_back('{st: 3'd2, ctrl: exec_ctrl(op), ill: 1'b0});
      if (op == LD) plan.push_back('{st: 3'd3, ctrl: mk(1, 0, 2'b00, 1, 0, 1, 0, 0), ill: 1'b0});
    end
    bus.opcode = op;
    for (int i = 0; i < plan.size() && i < limit; i++) begin
      #1;
      check($sformatf("state op=%b c%0d", op, i), 32'(bus.state), 32'(plan[i].st));
      check($sformatf("ctrl op=%b c%0d", op, i), 32'(obs_ctrl()), 32'(plan[i].ctrl));
      check($sformatf("illegal op=%b c%0d", op, i), 32'(bus.illegal), 32'(plan[i].ill));
      check($sformatf("retired op=%b c%0d", op, i), 32'(bus.retired), 32'(model_ret));
      if (plan[i].ctrl[2]) model_ret = (model_ret + 1) % (1 << CW);
      @(negedge CLK);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      #1;
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_ctrl", 32'(obs_ctrl()), 32'd0);
      check("rst_illegal", 32'(bus.illegal), 32'd0);
      check("rst_retired", 32'(bus.retired), 32'd0);
    end
    reset = 1'b0;
    model_ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    int idx;
    reset = 1'b1;
    bus.opcode = 7'b0;
    do_reset(2);

    run_instr(R, 0, 99);
    #1; check("r_retired", 32'(bus.retired), 32'd1);
    @(negedge CLK);
    // one idle FETCH cycle was consumed above; realign on a clean reset
    do_reset(1);

    run_instr(LD, 0, 99);
    run_instr(ST, 0, 99);
    run_instr(JAL, 0, 99);
    run_instr(JALR, 0, 99);
    #1; check("seq_retired", 32'(bus.retired), 32'd4);
    run_instr(BR, 0, 99);
    run_instr(AUIPC, 0, 99);

    run_instr(7'b1111111, 10, 99);
    do_reset(1);
    #1;
    check("post_halt_state", 32'(bus.state), 32'd0);
    check("post_halt_illegal", 32'(bus.illegal), 32'd0);

    run_instr(R, 0, 99);
    run_instr(LD, 0, 3);
    reset = 1'b1;
    #1;
    check("mem_rst_state", 32'(bus.state), 32'd3);
    check("mem_rst_ctrl", 32'(obs_ctrl()), 32'd0);
    @(negedge CLK);
    #1;
    check("mem_rst_after_state", 32'(bus.state), 32'd0);
    check("mem_rst_after_ret", 32'(bus.retired), 32'd0);
    reset = 1'b0;
    model_ret = 0;

    for (int i = 0; i < 15; i++) run_instr(R, 0, 99);
    #1; check("ret_max", 32'(bus.retired), 32'd15);
    run_instr(IA, 0, 99);
    #1; check("ret_wrap", 32'(bus.retired), 32'd0);

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 11);
      if (idx == 11) begin
        op = 7'($urandom);
        while (supported(op)) op = 7'($urandom);
        run_instr(op, 3, 99);
        do_reset(1);
      end else begin
        run_instr(ops[idx], 0, 99);
      end
    end
    #1; check("final_retired", 32'(bus.retired), 32'(model_ret));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
